// File: rtl/uart_pkg.sv
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared types and constants for the UART receive controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int FIFO_DEPTH   = 8;
    localparam int RST_PRESCALE = 8;
    localparam int TO_BITS      = 12;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACTIVE    = 2'd1,
        WAIT_HIGH = 2'd2
    } rx_state_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] val);
        return (val == 8'hFF) ? val : val + 8'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ============================================================================
// Module  : uart_rx_fifo
// Brief   : Show-ahead byte FIFO with sticky overrun flag.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic                           pop,
    input  logic [7:0]                     wr_data,
    input  logic                           ovr_clr,
    output logic [7:0]                     rd_data,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           overrun
);

    localparam int C_PTR_W = $clog2(DEPTH);
    localparam int C_CNT_W = $clog2(DEPTH + 1);

    logic [7:0]         r_mem [DEPTH];
    logic [C_PTR_W-1:0] r_wr_ptr;
    logic [C_PTR_W-1:0] r_rd_ptr;
    logic [C_CNT_W-1:0] r_count;
    logic               r_overrun;
    logic               w_do_push;
    logic               w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == C_CNT_W'(DEPTH));
    assign w_do_pop  = pop & ~empty;
    // A full FIFO still accepts a push when a pop frees the slot this cycle.
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + C_CNT_W'(1);
                2'b01:   r_count <= r_count - C_CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (ovr_clr) begin
                r_overrun <= 1'b0;
            end else if (push && !w_do_push) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign rd_data = empty ? 8'h00 : r_mem[r_rd_ptr];
    assign count   = r_count;
    assign overrun = r_overrun;

endmodule

`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
// ============================================================================
// Module  : uart_rx_ctrl
// Brief   : Frame supervisor, config shadowing and output FIFO for a UART RX.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_ctrl #(
    parameter int FIFO_DEPTH   = uart_pkg::FIFO_DEPTH,
    parameter int RST_PRESCALE = uart_pkg::RST_PRESCALE,
    parameter int TO_BITS      = uart_pkg::TO_BITS
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              rx_in,
    input  logic [7:0]                        p_data,
    input  logic                              data_valid,
    input  logic                              par_error,
    input  logic                              stop_error,
    output logic [5:0]                        prescale,
    output logic                              par_en,
    output logic                              par_typ,
    input  logic                              cfg_wr,
    input  logic [5:0]                        cfg_prescale,
    input  logic                              cfg_par_en,
    input  logic                              cfg_par_typ,
    output logic                              cfg_pending,
    output logic [7:0]                        out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic                              overrun,
    output logic [7:0]                        par_err_cnt,
    output logic [7:0]                        stop_err_cnt,
    output logic [7:0]                        timeout_cnt,
    input  logic                              err_clr
);

    import uart_pkg::*;

    logic [1:0] r_sync;
    logic       r_rx_prev;
    logic       w_rx_s;
    logic       w_rx_fall;

    logic       r_dv_prev, r_pe_prev, r_se_prev;
    logic       w_dv_rise, w_pe_rise, w_se_rise;
    logic       w_complete;

    rx_state_t  r_state, w_next_state;
    logic [9:0] r_timer;
    logic [9:0] w_limit;
    logic       w_timeout;

    logic [5:0] r_sh_prescale, r_prescale;
    logic       r_sh_par_en, r_par_en;
    logic       r_sh_par_typ, r_par_typ;
    logic       r_cfg_pending;
    logic       w_apply;

    logic [7:0] r_par_cnt, r_stop_cnt, r_to_cnt;
    logic       w_push;
    logic       w_pop;
    logic       w_full, w_empty;

    assign w_rx_s    = r_sync[1];
    assign w_rx_fall = r_rx_prev & ~w_rx_s;

    assign w_dv_rise  = data_valid & ~r_dv_prev;
    assign w_pe_rise  = par_error  & ~r_pe_prev;
    assign w_se_rise  = stop_error & ~r_se_prev;
    assign w_complete = w_dv_rise | w_pe_rise | w_se_rise;

    assign w_limit   = 10'({4'd0, r_prescale} * 10'(TO_BITS)) - 10'd1;
    // A completion in the same cycle as the limit wins; no timeout is counted.
    assign w_timeout = (r_state == ACTIVE) && !w_complete && (r_timer == w_limit);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync    <= 2'b11;
            r_rx_prev <= 1'b1;
            r_dv_prev <= 1'b0;
            r_pe_prev <= 1'b0;
            r_se_prev <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], rx_in};
            r_rx_prev <= w_rx_s;
            r_dv_prev <= data_valid;
            r_pe_prev <= par_error;
            r_se_prev <= stop_error;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:      if (w_rx_fall) w_next_state = ACTIVE;
            ACTIVE:    if (w_complete || w_timeout) w_next_state = WAIT_HIGH;
            WAIT_HIGH: if (w_rx_s) w_next_state = IDLE;
            default:   w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_timer <= '0;
        end else if (r_state == IDLE && w_rx_fall) begin
            r_timer <= '0;
        end else if (r_state == ACTIVE) begin
            r_timer <= r_timer + 10'd1;
        end
    end

    // Shadow updates freely; the live copy only changes between frames.
    assign w_apply = (r_state == IDLE) && r_cfg_pending;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sh_prescale <= 6'(RST_PRESCALE);
            r_sh_par_en   <= 1'b0;
            r_sh_par_typ  <= 1'b0;
            r_cfg_pending <= 1'b0;
            r_prescale    <= 6'(RST_PRESCALE);
            r_par_en      <= 1'b0;
            r_par_typ     <= 1'b0;
        end else begin
            if (w_apply) begin
                r_prescale <= r_sh_prescale;
                r_par_en   <= r_sh_par_en;
                r_par_typ  <= r_sh_par_typ;
            end
            if (cfg_wr) begin
                r_sh_prescale <= (cfg_prescale == 6'd0) ? 6'd1 : cfg_prescale;
                r_sh_par_en   <= cfg_par_en;
                r_sh_par_typ  <= cfg_par_typ;
                r_cfg_pending <= 1'b1;
            end else if (w_apply) begin
                r_cfg_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_par_cnt  <= 8'd0;
            r_stop_cnt <= 8'd0;
            r_to_cnt   <= 8'd0;
        end else if (err_clr) begin
            r_par_cnt  <= 8'd0;
            r_stop_cnt <= 8'd0;
            r_to_cnt   <= 8'd0;
        end else begin
            if (w_pe_rise) r_par_cnt  <= sat_inc(r_par_cnt);
            if (w_se_rise) r_stop_cnt <= sat_inc(r_stop_cnt);
            if (w_timeout) r_to_cnt   <= sat_inc(r_to_cnt);
        end
    end

    assign w_push = w_dv_rise & ~par_error & ~stop_error;
    assign w_pop  = out_ready & ~w_empty;

    uart_rx_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (w_push),
        .pop     (w_pop),
        .wr_data (p_data),
        .ovr_clr (err_clr),
        .rd_data (out_data),
        .full    (w_full),
        .empty   (w_empty),
        .count   (fifo_count),
        .overrun (overrun)
    );

    assign out_valid    = ~w_empty;
    assign prescale     = r_prescale;
    assign par_en       = r_par_en;
    assign par_typ      = r_par_typ;
    assign cfg_pending  = r_cfg_pending;
    assign par_err_cnt  = r_par_cnt;
    assign stop_err_cnt = r_stop_cnt;
    assign timeout_cnt  = r_to_cnt;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
// ============================================================================
// Module  : tb_uart_rx_ctrl
// Brief   : Directed self-checking bench for uart_rx_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_in = 1'b1;
    logic [7:0] p_data = 8'h00;
    logic       data_valid = 1'b0, par_error = 1'b0, stop_error = 1'b0;
    logic [5:0] prescale;
    logic       par_en, par_typ;
    logic       cfg_wr = 1'b0;
    logic [5:0] cfg_prescale = 6'd8;
    logic       cfg_par_en = 1'b0, cfg_par_typ = 1'b0;
    logic       cfg_pending;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] fifo_count;
    logic       overrun;
    logic [7:0] par_err_cnt, stop_err_cnt, timeout_cnt;
    logic       err_clr = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_rx_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .rx_in        (rx_in),
        .p_data       (p_data),
        .data_valid   (data_valid),
        .par_error    (par_error),
        .stop_error   (stop_error),
        .prescale     (prescale),
        .par_en       (par_en),
        .par_typ      (par_typ),
        .cfg_wr       (cfg_wr),
        .cfg_prescale (cfg_prescale),
        .cfg_par_en   (cfg_par_en),
        .cfg_par_typ  (cfg_par_typ),
        .cfg_pending  (cfg_pending),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .fifo_count   (fifo_count),
        .overrun      (overrun),
        .par_err_cnt  (par_err_cnt),
        .stop_err_cnt (stop_err_cnt),
        .timeout_cnt  (timeout_cnt),
        .err_clr      (err_clr)
    );

    typedef struct {
        int         kind;     // 0 frame, 1 pop, 2 error clear
        logic [7:0] b;
        logic       pe;
        logic       se;
        logic [3:0] e_cnt;
        logic       e_valid;
        logic [7:0] e_data;
        logic [7:0] e_par;
        logic [7:0] e_stop;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame(input logic [7:0] b, input logic pe, input logic se);
        rx_in = 1'b0;
        tick(6);
        p_data = b; data_valid = 1'b1; par_error = pe; stop_error = se;
        tick(1);
        data_valid = 1'b0; par_error = 1'b0; stop_error = 1'b0; rx_in = 1'b1;
        tick(5);
    endtask

    task automatic pop1();
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
    endtask

    task automatic clr();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
    endtask

    task automatic cfg(input logic [5:0] ps, input logic pen, input logic pty);
        cfg_prescale = ps; cfg_par_en = pen; cfg_par_typ = pty; cfg_wr = 1'b1;
        tick(1);
        cfg_wr = 1'b0;
    endtask

    logic [7:0] ovf_bytes [9];

    initial begin
        vecs[0]  = '{0, 8'hA5, 0, 0, 4'd1, 1, 8'hA5, 8'd0, 8'd0};
        vecs[1]  = '{1, 8'h00, 0, 0, 4'd0, 0, 8'h00, 8'd0, 8'd0};
        vecs[2]  = '{0, 8'h3C, 0, 0, 4'd1, 1, 8'h3C, 8'd0, 8'd0};
        vecs[3]  = '{0, 8'h7E, 1, 0, 4'd1, 1, 8'h3C, 8'd1, 8'd0};
        vecs[4]  = '{0, 8'h11, 0, 1, 4'd1, 1, 8'h3C, 8'd1, 8'd1};
        vecs[5]  = '{0, 8'h22, 1, 1, 4'd1, 1, 8'h3C, 8'd2, 8'd2};
        vecs[6]  = '{0, 8'h5A, 0, 0, 4'd2, 1, 8'h3C, 8'd2, 8'd2};
        vecs[7]  = '{1, 8'h00, 0, 0, 4'd1, 1, 8'h5A, 8'd2, 8'd2};
        vecs[8]  = '{1, 8'h00, 0, 0, 4'd0, 0, 8'h00, 8'd2, 8'd2};
        vecs[9]  = '{2, 8'h00, 0, 0, 4'd0, 0, 8'h00, 8'd0, 8'd0};
        vecs[10] = '{1, 8'h00, 0, 0, 4'd0, 0, 8'h00, 8'd0, 8'd0};
        ovf_bytes = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF, 8'hF0};

        // Reset values
        tick(2);
        chk("rst_count", fifo_count, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_prescale", prescale, 8);
        chk("rst_par_en", par_en, 0);
        chk("rst_pending", cfg_pending, 0);
        chk("rst_overrun", overrun, 0);
        rst = 1'b1;
        tick(2);

        // Transaction table
        for (int i = 0; i < 11; i++) begin
            case (vecs[i].kind)
                0:       frame(vecs[i].b, vecs[i].pe, vecs[i].se);
                1:       pop1();
                default: clr();
            endcase
            chk($sformatf("v%0d_count", i), fifo_count, vecs[i].e_cnt);
            chk($sformatf("v%0d_valid", i), out_valid, vecs[i].e_valid);
            chk($sformatf("v%0d_data", i), out_data, vecs[i].e_data);
            chk($sformatf("v%0d_par", i), par_err_cnt, vecs[i].e_par);
            chk($sformatf("v%0d_stop", i), stop_err_cnt, vecs[i].e_stop);
        end

        // Overflow, then simultaneous push and pop while full
        for (int i = 0; i < 9; i++) frame(ovf_bytes[i], 1'b0, 1'b0);
        chk("ovf_count", fifo_count, 8);
        chk("ovf_flag", overrun, 1);
        chk("ovf_head", out_data, 8'h01);
        p_data = 8'hEE; data_valid = 1'b1; out_ready = 1'b1;
        tick(1);
        data_valid = 1'b0; out_ready = 1'b0;
        chk("full_pushpop_count", fifo_count, 8);
        for (int i = 1; i < 8; i++) begin
            chk($sformatf("drain%0d", i), out_data, ovf_bytes[i]);
            pop1();
        end
        chk("drain_last", out_data, 8'hEE);
        pop1();
        chk("drain_count", fifo_count, 0);
        chk("ovf_sticky", overrun, 1);
        clr();
        chk("ovf_cleared", overrun, 0);

        // Config written mid-frame is held off until IDLE
        rx_in = 1'b0;
        tick(4);
        cfg(6'd16, 1'b0, 1'b0);
        chk("cfg_hold_ps", prescale, 8);
        chk("cfg_hold_pend", cfg_pending, 1);
        tick(2);
        chk("cfg_hold_ps2", prescale, 8);
        par_error = 1'b1; rx_in = 1'b1;
        tick(1);
        par_error = 1'b0;
        tick(6);
        chk("cfg_applied_ps", prescale, 16);
        chk("cfg_applied_pend", cfg_pending, 0);
        chk("cfg_frame_par", par_err_cnt, 1);
        cfg(6'd0, 1'b0, 1'b0);
        tick(1);
        chk("cfg_zero_ps", prescale, 1);
        // Second write lands on the same edge the first one is applied
        cfg_prescale = 6'd5; cfg_par_en = 1'b1; cfg_par_typ = 1'b1; cfg_wr = 1'b1;
        tick(1);
        cfg_prescale = 6'd8; cfg_par_en = 1'b1; cfg_par_typ = 1'b0;
        tick(1);
        cfg_wr = 1'b0;
        chk("cfg_race_ps", prescale, 5);
        chk("cfg_race_typ", par_typ, 1);
        chk("cfg_race_pend", cfg_pending, 1);
        tick(1);
        chk("cfg_final_ps", prescale, 8);
        chk("cfg_final_en", par_en, 1);
        chk("cfg_final_typ", par_typ, 0);
        chk("cfg_final_pend", cfg_pending, 0);

        // Parity error counter saturation
        clr();
        for (int i = 0; i < 256; i++) frame(8'h00, 1'b1, 1'b0);
        chk("par_sat", par_err_cnt, 255);
        chk("par_fifo", fifo_count, 0);

        // Timeout at prescale 8 and WAIT_HIGH hold
        rx_in = 1'b0;
        tick(98);
        chk("to_before", timeout_cnt, 0);
        tick(1);
        chk("to_after", timeout_cnt, 1);
        cfg(6'd8, 1'b0, 1'b0);
        tick(20);
        chk("to_wait_pend", cfg_pending, 1);
        chk("to_no_repeat", timeout_cnt, 1);
        rx_in = 1'b1;
        tick(4);
        chk("to_idle_pend", cfg_pending, 0);

        // Asynchronous reset mid-frame with queued bytes
        frame(8'h31, 1'b0, 1'b0);
        frame(8'h32, 1'b0, 1'b0);
        frame(8'h33, 1'b0, 1'b0);
        chk("q3_count", fifo_count, 3);
        rx_in = 1'b0;
        tick(4);
        cfg(6'd20, 1'b1, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("arst_count", fifo_count, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_data", out_data, 0);
        chk("arst_par", par_err_cnt, 0);
        chk("arst_to", timeout_cnt, 0);
        chk("arst_pend", cfg_pending, 0);
        chk("arst_ps", prescale, 8);
        @(negedge clk);
        rst = 1'b1; rx_in = 1'b1;
        tick(5);
        chk("post_ps", prescale, 8);
        chk("post_en", par_en, 0);
        chk("post_pend", cfg_pending, 0);
        chk("post_count", fifo_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all logic on its rising edge.
REQ-002 SHALL have port: rst  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: rx_in  input  1  serial line, monitored in parallel with the receiver.
REQ-004 SHALL have ports: p_data  input  8, data_valid  input  1, par_error  input  1, stop_error  input  1  (receiver status).
REQ-005 SHALL have ports: prescale  output  6, par_en  output  1, par_typ  output  1  (receiver configuration).
REQ-006 SHALL have ports: cfg_wr  input  1 pulse, cfg_prescale  input  6, cfg_par_en  input  1, cfg_par_typ  input  1, cfg_pending  output  1.
REQ-007 SHALL have ports: out_data  output  8, out_valid  output  1, out_ready  input  1  (consumer handshake).
REQ-008 SHALL have ports: fifo_count  output  4, overrun  output  1, par_err_cnt  output  8, stop_err_cnt  output  8, timeout_cnt  output  8, err_clr  input  1.
REQ-009 SHALL use parameters (name, default, meaning): FIFO_DEPTH 8 entries; RST_PRESCALE 8 reset oversampling; TO_BITS 12 timeout length in bit-times.

Function
REQ-010 SHALL pass rx_in through a 2-flop synchroniser; all line decisions use the synchronised value rx_s.
REQ-011 SHALL run FSM states IDLE, ACTIVE, WAIT_HIGH.
REQ-012 IDLE -> ACTIVE on rx_s high-to-low transition; frame timer cleared to 0.
REQ-013 ACTIVE: frame timer increments each cycle; completion event = rising edge of data_valid, par_error or stop_error -> WAIT_HIGH.
REQ-014 ACTIVE: timer reaching prescale*TO_BITS - 1 (10-bit compare) without completion -> WAIT_HIGH; timeout_cnt +1.
REQ-015 WAIT_HIGH -> IDLE on first cycle rx_s = 1 (may be the entry cycle's next cycle).
REQ-016 On data_valid rising edge with par_error and stop_error both low, p_data SHALL be pushed to the FIFO.
REQ-017 par_error rising edge increments par_err_cnt; stop_error rising edge increments stop_err_cnt; errored frames not pushed; both edges same cycle increment both.
REQ-018 All error counters saturate at 255; err_clr zeroes them and overrun next cycle, err_clr winning over a same-cycle increment.
REQ-019 FIFO show-ahead: out_data = head entry, out_valid = (fifo_count != 0); pop when out_valid and out_ready.
REQ-020 Push when full with no same-cycle pop: data dropped, overrun set (sticky); push and pop same cycle when full: both accepted, count stays 8.
REQ-021 Push and pop same cycle when not empty: count unchanged; pop when empty: ignored.
REQ-022 Pointers 3-bit wrap modulo 8; fifo_count 0..8.
REQ-023 cfg_wr captures cfg_* into shadow, sets cfg_pending; later cfg_wr before apply overwrites shadow.
REQ-024 Shadow applied to prescale/par_en/par_typ on the first clock edge with FSM in IDLE and cfg_pending=1; cfg_pending clears same edge; never applied in ACTIVE/WAIT_HIGH.
REQ-025 cfg_wr in the same cycle as apply: new values captured, cfg_pending remains 1, applied next IDLE cycle.
REQ-026 cfg_prescale = 0 SHALL be treated as 1 when captured.

Reset
REQ-027 On rst low, asynchronously: FSM IDLE, synchroniser flops 1, timer 0, FIFO empty, out_valid 0, out_data 0, all counters 0, overrun 0, cfg_pending 0, prescale RST_PRESCALE, par_en 0, par_typ 0.
REQ-028 Reset mid-frame or mid-handshake SHALL discard FIFO contents and shadow; no output glitch beyond reset values.

Structure
REQ-029 Shared package uart_pkg SHALL hold the FSM state type, FIFO_DEPTH, RST_PRESCALE, TO_BITS.
REQ-030 FIFO SHALL be a sub-module uart_rx_fifo (push, pop, full, empty, count, overrun); controller does not instantiate the receiver.

Verification
REQ-031 Good frame 0xA5 (prescale 8, no parity) -> fifo_count 1, out_valid 1, out_data 0xA5; out_ready pulse -> fifo_count 0.
REQ-032 Nine good frames, out_ready 0 -> fifo_count 8, overrun 1, entries equal first eight bytes; err_clr -> overrun 0.
REQ-033 Frame with par_error pulse (par_en 1) -> par_err_cnt 1, FIFO unchanged; 256 such frames -> par_err_cnt 255.
REQ-034 cfg_wr prescale 16 while ACTIVE -> prescale stays 8, cfg_pending 1 until IDLE, then prescale 16, cfg_pending 0.
REQ-035 rx_in held low, no completion -> timeout after 96 cycles (prescale 8), timeout_cnt 1, FSM waits in WAIT_HIGH until rx_in 1.
REQ-036 rst low during ACTIVE with 3 queued bytes -> all outputs at reset values immediately, fifo_count 0.
